serial_word_tx: RTL

//  Parallel-in/serial-out transmitter that drives the 1-bit stream x_in of the sequence detector.

---
 rtl/serial_word_tx_pkg.sv | 16 +
 rtl/serial_word_tx_piso_shift_reg.sv | 34 +++
 rtl/serial_word_tx.sv | 120 ++++++++++++
 3 files changed

// File: rtl/serial_word_tx_pkg.sv
// serial_word_tx_pkg
//   Shared definitions for the serial word transmitter: FSM state encoding
//   and counter widths. Imported by serial_word_tx.
package serial_word_tx_pkg;

  // Transmitter FSM encoding (2-bit).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_t;

  // Gap counter is fixed at 4 bits (GAP up to 15).
  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/serial_word_tx_piso_shift_reg.sv
// piso_shift_reg
//   Parallel-in / serial-out shift register. Loads a word, then presents one
//   bit per enabled shift, starting at the MSB or the LSB.
// Ports
//   i_clk    clock
//   i_rst    async active-high reset (clears the register)
//   i_load   parallel load of i_data (has priority over i_shift)
//   i_data   word to load
//   i_shift  advance to the next bit
//   o_bit    bit currently presented
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_shift,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_sh;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_sh <= '0;
    else if (i_load)  r_sh <= i_data;
    else if (i_shift) r_sh <= MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0}
                                        : {1'b0, r_sh[WIDTH-1:1]};
  end

  assign o_bit = MSB_FIRST ? r_sh[WIDTH-1] : r_sh[0];

endmodule

// File: rtl/serial_word_tx.sv
// serial_word_tx
//   Parallel-in / serial-out transmitter feeding a 1-bit detector stream.
//   One-word holding register behind a valid/ready handshake; each word is
//   shifted out one bit per clock followed by GAP idle bit-times. The line
//   rests at IDLE_LEVEL whenever no data bit is being driven.
// Ports
//   clock       rising-edge clock
//   reset       async active-high reset; discards held and in-flight words
//   data_in     word to send, captured when load_valid && load_ready
//   load_valid  upstream offers data_in
//   load_ready  holding register empty (registered)
//   x_out       serial bit stream
//   busy        SHIFT or GAP in progress, or holding register full
//   frame_done  high while the last data bit of a word is driven
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP        = 2,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             busy,
  output logic             frame_done
);

  localparam int BCW = $clog2(WIDTH);
  localparam logic [BCW-1:0]       BIT_LAST = BCW'(WIDTH - 1);
  // Only meaningful when GAP > 0; the GAP state is never entered otherwise.
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;

  tx_state_t            r_state, w_next;
  logic [BCW-1:0]       r_bit_cnt;
  logic [GAP_CNT_W-1:0] r_gap_cnt;
  logic [WIDTH-1:0]     r_hold;
  logic                 r_hold_full;

  logic w_last_bit, w_gap_end, w_xfer, w_accept, w_bit;

  assign w_last_bit = (r_state == ST_SHIFT) && (r_bit_cnt == BIT_LAST);
  assign w_gap_end  = (r_state == ST_GAP)   && (r_gap_cnt == GAP_LAST);
  // Hold->shifter move happens exactly when the line would otherwise free up,
  // which gives zero lost cycles between back-to-back words.
  assign w_xfer     = r_hold_full &&
                      ((r_state == ST_IDLE) || w_gap_end || (w_last_bit && (GAP == 0)));
  // load_ready is !r_hold_full, so accept and transfer are mutually exclusive.
  assign w_accept   = load_valid && !r_hold_full;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_xfer) w_next = ST_SHIFT;
      ST_SHIFT: if (w_last_bit)
                  w_next = (GAP > 0) ? ST_GAP : (w_xfer ? ST_SHIFT : ST_IDLE);
      ST_GAP:   if (w_gap_end) w_next = w_xfer ? ST_SHIFT : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Bit / gap counters; both saturate at their last value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (w_xfer)                               r_bit_cnt <= '0;
      else if (r_state == ST_SHIFT && !w_last_bit) r_bit_cnt <= r_bit_cnt + 1'b1;

      if (w_last_bit)                           r_gap_cnt <= '0;
      else if (r_state == ST_GAP && !w_gap_end) r_gap_cnt <= r_gap_cnt + 1'b1;
    end
  end

  // Holding register and handshake
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_xfer) begin
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= data_in;
      r_hold_full <= 1'b1;
    end
  end

  piso_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_piso (
    .i_clk  (clock),
    .i_rst  (reset),
    .i_load (w_xfer),
    .i_data (r_hold),
    .i_shift((r_state == ST_SHIFT) && !w_last_bit),
    .o_bit  (w_bit)
  );

  // Outputs; state resets asynchronously so x_out idles immediately on reset.
  always_comb begin
    x_out      = (r_state == ST_SHIFT) ? w_bit : IDLE_LEVEL;
    load_ready = !r_hold_full;
    busy       = (r_state != ST_IDLE) || r_hold_full;
    frame_done = w_last_bit;
  end

endmodule
